// File: rtl/smart_led_bit_decoder.sv
// Smart-LED single-wire bit decoder: measures high-pulse widths,
// captures the first 24 bits after a latch gap and forwards the rest.
module smart_led_bit_decoder #(
  parameter int unsigned THRESH    = 6,
  parameter int unsigned RESET_LOW = 500,
  parameter int unsigned HIGH_MAX  = 100,
  parameter int unsigned CNT_W     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        din,
  output logic [23:0] data_out,
  output logic        data_valid,
  output logic        latch_strobe,
  output logic        passthrough,
  output logic        dout,
  output logic        error
);

  typedef enum logic [1:0] {
    RECV,
    PASS,
    ERR
  } state_t;

  localparam logic [CNT_W-1:0] TH   = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] RLOW = CNT_W'(RESET_LOW);
  localparam logic [CNT_W-1:0] HMAX = CNT_W'(HIGH_MAX);

  state_t state_q;
  state_t state_d;

  logic             din_d;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] low_cnt;
  logic [4:0]       bit_cnt;
  logic [23:0]      shift;

  logic fall;
  logic bit_val;
  logic latch_hit;
  logic err_hit;
  logic word_done;

  assign fall      = din_d & ~din;
  assign bit_val   = high_cnt > TH;
  assign latch_hit = ~din && (low_cnt == RLOW - 1'b1);
  assign err_hit   = din && (high_cnt == HMAX - 1'b1)
                     && (state_q != ERR);
  assign word_done = (state_q == RECV) && fall
                     && (bit_cnt == 5'd23);

  assign passthrough = (state_q == PASS);

  // latch, err and word_done are mutually exclusive by din level
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      latch_hit: state_d = RECV;
      err_hit:   state_d = ERR;
      word_done: state_d = PASS;
      default:   state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RECV;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_d        <= 1'b0;
      high_cnt     <= '0;
      low_cnt      <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      data_out     <= '0;
      data_valid   <= 1'b0;
      latch_strobe <= 1'b0;
      dout         <= 1'b0;
      error        <= 1'b0;
    end else begin
      din_d        <= din;
      latch_strobe <= latch_hit;
      data_valid   <= word_done;

      if (din) begin
        high_cnt <= (high_cnt == HMAX) ? HMAX
                                       : high_cnt + 1'b1;
        low_cnt  <= '0;
      end else begin
        high_cnt <= '0;
        low_cnt  <= (low_cnt == RLOW) ? RLOW
                                      : low_cnt + 1'b1;
      end

      if (latch_hit) begin
        bit_cnt <= '0;
        shift   <= '0;
        error   <= 1'b0;
      end else if (err_hit) begin
        error <= 1'b1;
      end else if (state_q == RECV && fall) begin
        shift <= {shift[22:0], bit_val};
        if (word_done) begin
          data_out <= {shift[22:0], bit_val};
          bit_cnt  <= '0;
        end else begin
          bit_cnt <= bit_cnt + 5'd1;
        end
      end

      // forwarding is a plain 1-cycle delay of din while in PASS
      dout <= (state_q == PASS && !latch_hit && !err_hit)
              ? din : 1'b0;
    end
  end

endmodule

// File: tb/tb_smart_led_bit_decoder.sv
// Randomized bench for smart_led_bit_decoder against a
// run-length reference model of the LED protocol.
module tb_smart_led_bit_decoder;

  localparam int THRESH    = 6;
  localparam int RESET_LOW = 500;
  localparam int HIGH_MAX  = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic [23:0] data_out;
  logic        data_valid;
  logic        latch_strobe;
  logic        passthrough;
  logic        dout;
  logic        error;

  smart_led_bit_decoder #(
    .THRESH(THRESH),
    .RESET_LOW(RESET_LOW),
    .HIGH_MAX(HIGH_MAX),
    .CNT_W(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .data_out(data_out),
    .data_valid(data_valid),
    .latch_strobe(latch_strobe),
    .passthrough(passthrough),
    .dout(dout),
    .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: run lengths, mode 0=recv 1=pass 2=err, bit list
  int          m_hi;
  int          m_lo;
  int          m_mode;
  logic        m_prev;
  logic        m_bits[$];
  logic [23:0] m_data;
  logic        m_dv;
  logic        m_ls;
  logic        m_dout;
  logic        m_err;

  int dv_seen;
  int ls_seen;
  int dout_hi;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hi = 0;
    m_lo = 0;
    m_mode = 0;
    m_prev = 1'b0;
    m_bits.delete();
    m_data = '0;
    m_dv = 1'b0;
    m_ls = 1'b0;
    m_dout = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic d);
    int   mode0;
    logic ehit;
    logic lhit;
    mode0 = m_mode;
    ehit = 1'b0;
    lhit = 1'b0;
    m_dv = 1'b0;
    m_ls = 1'b0;
    if (d) begin
      m_hi++;
      m_lo = 0;
      if (m_hi == HIGH_MAX && m_mode != 2) begin
        ehit = 1'b1;
        m_mode = 2;
        m_err = 1'b1;
      end
    end else begin
      if (m_prev && m_mode == 0) begin
        m_bits.push_back(m_hi > THRESH);
        if (m_bits.size() == 24) begin
          m_data = '0;
          for (int i = 0; i < 24; i++)
            m_data = {m_data[22:0], m_bits[i]};
          m_bits.delete();
          m_dv = 1'b1;
          m_mode = 1;
        end
      end
      m_hi = 0;
      m_lo++;
      if (m_lo == RESET_LOW) begin
        lhit = 1'b1;
        m_ls = 1'b1;
        m_mode = 0;
        m_bits.delete();
        m_err = 1'b0;
      end
    end
    m_dout = (mode0 == 1 && !lhit && !ehit) ? d : 1'b0;
    m_prev = d;
  endtask

  task automatic step(input logic d);
    din = d;
    @(posedge clk);
    model_step(d);
    @(negedge clk);
    chk("dout", 32'(dout), 32'(m_dout));
    chk("data_valid", 32'(data_valid), 32'(m_dv));
    chk("latch_strobe", 32'(latch_strobe), 32'(m_ls));
    chk("passthrough", 32'(passthrough), 32'(m_mode == 1));
    chk("error", 32'(error), 32'(m_err));
    chk("data_out", 32'(data_out), 32'(m_data));
    if (data_valid) dv_seen++;
    if (latch_strobe) ls_seen++;
    if (dout) dout_hi++;
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) step(1'b1);
    for (int i = 0; i < lo; i++) step(1'b0);
  endtask

  task automatic send_bit(input logic b);
    if (b) pulse(8, 4);
    else pulse(4, 8);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic low(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic clr_counts();
    dv_seen = 0;
    ls_seen = 0;
    dout_hi = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      din = ~din;
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    model_reset();
    chk("rst_data_out", 32'(data_out), 32'h0);
    chk("rst_data_valid", 32'(data_valid), 32'h0);
    chk("rst_latch", 32'(latch_strobe), 32'h0);
    chk("rst_pass", 32'(passthrough), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_error", 32'(error), 32'h0);
  endtask

  initial begin
    logic [23:0] w;
    logic [23:0] keep;
    int hi;
    clr_counts();
    model_reset();
    @(negedge clk);
    do_reset();

    // single frame
    clr_counts();
    low(600);
    send_word(24'hA5C3F0);
    chk("single_data", 32'(data_out), 32'hA5C3F0);
    chk("single_dv_cnt", 32'(dv_seen), 32'd1);
    chk("single_ls_cnt", 32'(ls_seen), 32'd1);
    chk("single_dout_hi", 32'(dout_hi), 32'd0);
    chk("single_pass", 32'(passthrough), 32'd1);

    // chain forward
    low(RESET_LOW);
    clr_counts();
    send_word(24'hA5C3F0);
    send_word(24'h123456);
    chk("chain_dv_cnt", 32'(dv_seen), 32'd1);
    chk("chain_data", 32'(data_out), 32'hA5C3F0);
    chk("chain_dout_hi", 32'(dout_hi),
        32'($countones(24'h123456) * 8
            + (24 - $countones(24'h123456)) * 4));
    low(RESET_LOW);
    chk("chain_ls_cnt", 32'(ls_seen), 32'd1);
    chk("chain_dout_end", 32'(dout), 32'd0);
    chk("chain_pass_end", 32'(passthrough), 32'd0);

    // abort a partial word
    clr_counts();
    for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
    low(RESET_LOW);
    chk("abort_dv_cnt", 32'(dv_seen), 32'd0);
    chk("abort_ls_cnt", 32'(ls_seen), 32'd1);
    chk("abort_keep", 32'(data_out), 32'hA5C3F0);
    send_word(24'h00FF00);
    chk("abort_next", 32'(data_out), 32'h00FF00);

    // threshold boundary on the last bit
    low(RESET_LOW);
    for (int i = 0; i < 23; i++) send_bit(1'b1);
    pulse(THRESH, 6);
    chk("thresh_eq", 32'(data_out), 32'hFFFFFE);
    low(RESET_LOW);
    for (int i = 0; i < 23; i++) send_bit(1'b1);
    pulse(THRESH + 1, 5);
    chk("thresh_gt", 32'(data_out), 32'hFFFFFF);

    // a low of RESET_LOW-1 is not a latch
    low(RESET_LOW);
    clr_counts();
    w = 24'($urandom);
    for (int i = 23; i >= 12; i--) send_bit(w[i]);
    pulse(w[11] ? 8 : 4, RESET_LOW - 1);
    for (int i = 10; i >= 0; i--) send_bit(w[i]);
    chk("gap_ls_cnt", 32'(ls_seen), 32'd0);
    chk("gap_data", 32'(data_out), 32'(w));

    // malformed long high
    low(RESET_LOW);
    keep = data_out;
    clr_counts();
    for (int i = 0; i < HIGH_MAX - 1; i++) step(1'b1);
    chk("err_early", 32'(error), 32'd0);
    step(1'b1);
    chk("err_set", 32'(error), 32'd1);
    low(20);
    send_word(24'($urandom));
    chk("err_dv_cnt", 32'(dv_seen), 32'd0);
    chk("err_keep", 32'(data_out), 32'(keep));
    low(RESET_LOW);
    chk("err_clr", 32'(error), 32'd0);
    w = 24'($urandom);
    send_word(w);
    chk("err_next", 32'(data_out), 32'(w));

    // reset mid-PASS and mid-word
    send_bit(1'b1);
    do_reset();
    for (int i = 0; i < 10; i++) send_bit(1'b0);
    do_reset();
    low(RESET_LOW);
    w = 24'($urandom);
    send_word(w);
    chk("post_rst_data", 32'(data_out), 32'(w));

    // random widths, random forwarded tail, occasional error in PASS
    for (int n = 0; n < 6; n++) begin
      low(RESET_LOW + $urandom_range(0, 40));
      w = '0;
      for (int i = 0; i < 24; i++) begin
        hi = $urandom_range(1, 11);
        w = {w[22:0], 1'(hi > THRESH)};
        pulse(hi, $urandom_range(2, 10));
      end
      chk("rand_data", 32'(data_out), 32'(w));
      for (int i = 0; i < int'($urandom_range(0, 5)); i++)
        pulse($urandom_range(1, 20), $urandom_range(1, 20));
      if (n % 2 == 1) begin
        pulse(HIGH_MAX + 5, 3);
        chk("rand_err", 32'(error), 32'd1);
      end
    end
    low(RESET_LOW);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
